// File: rtl/exp5_unidade_exibicao.sv
// Sequence presenter: walks the sequence ROM from address 0 to limite, showing each value on the LEDs.
// Optional pause input enabled by defining EXIBICAO_PAUSA_EN.
module exp5_unidade_exibicao #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado,
`ifdef EXIBICAO_PAUSA_EN
    input  logic              pausa,
`endif
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        CARREGA    = 4'h2,
        MOSTRA     = 4'h3,
        APAGA      = 4'h4,
        PROXIMO    = 4'h5,
        FIM        = 4'hA
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [15:0]       timer_q, timer_d;
    logic              congelado;

`ifdef EXIBICAO_PAUSA_EN
    assign congelado = pausa;
`else
    assign congelado = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIAL;
            endereco_q <= '0;
            limite_q   <= '0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            limite_q   <= limite_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        timer_d    = 16'd0;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                endereco_d = '0;
                limite_d   = limite;
                estado_d   = CARREGA;
            end
            // Gives the synchronous ROM one cycle to present dado for the new address.
            CARREGA: estado_d = MOSTRA;
            MOSTRA: begin
                if (congelado) begin
                    timer_d = timer_q;
                end else if (timer_q == 16'(T_ON - 1)) begin
                    estado_d = APAGA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            APAGA: begin
                if (congelado) begin
                    timer_d = timer_q;
                end else if (timer_q == 16'(T_OFF - 1)) begin
                    // Finish is decided before incrementing, so a full-range run never wraps.
                    estado_d = (endereco_q == limite_q) ? FIM : PROXIMO;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            PROXIMO: begin
                endereco_d = endereco_q + ADDR_W'(1);
                estado_d   = CARREGA;
            end
            FIM:     estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    always_comb begin
        case (estado_q)
            INICIAL, PREPARACAO, CARREGA, MOSTRA, APAGA, PROXIMO, FIM: db_estado = estado_q;
            default: db_estado = 4'hF;
        endcase
    end

    assign endereco = endereco_q;
    assign leds     = (estado_q == MOSTRA) ? dado : '0;
    assign exibindo = (estado_q != INICIAL) && (estado_q != FIM);
    assign pronto   = (estado_q == FIM);

endmodule

// File: tb/tb_exp5_unidade_exibicao.sv
// Bench for exp5_unidade_exibicao: expected per-cycle timelines built from the presentation rules.
module tb_exp5_unidade_exibicao;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              iniciar = 1'b0;
    logic [ADDR_W-1:0] limite = '0;
    logic [DATA_W-1:0] dado = '0;
    logic              pausa = 1'b0;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              exibindo;
    logic              pronto;
    logic [3:0]        db_estado;

    exp5_unidade_exibicao #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .T_ON(T_ON), .T_OFF(T_OFF)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite), .dado(dado),
`ifdef EXIBICAO_PAUSA_EN
        .pausa(pausa),
`endif
        .endereco(endereco), .leds(leds), .exibindo(exibindo), .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous sequence ROM.
    logic [DATA_W-1:0] rom [16];
    always @(posedge clock) dado <= rom[endereco];

    typedef struct {
        logic [3:0]        st;
        logic [DATA_W-1:0] lv;
        logic [ADDR_W-1:0] ad;
        logic              ex;
        logic              pr;
    } exp_t;

    typedef struct {
        int lim;
        int exp_latency;
        int exp_led_cycles;
    } vec_t;

    exp_t trace[$];
    int   errors = 0;
    int   checks = 0;
    int   last_end = 0;

    function automatic exp_t mk(input int st, input int lv, input int ad, input bit ex, input bit pr);
        exp_t e;
        e.st = 4'(st); e.lv = DATA_W'(lv); e.ad = ADDR_W'(ad); e.ex = ex; e.pr = pr;
        return e;
    endfunction

    task automatic check_cycle(input exp_t e, input string tag, input int idx);
        checks++;
        if (db_estado !== e.st || leds !== e.lv || endereco !== e.ad ||
            exibindo !== e.ex || pronto !== e.pr) begin
            errors++;
            $display("FAIL %s[%0d]: got st=%h leds=%h end=%h exib=%b pronto=%b, want st=%h leds=%h end=%h exib=%b pronto=%b",
                     tag, idx, db_estado, leds, endereco, exibindo, pronto,
                     e.st, e.lv, e.ad, e.ex, e.pr);
        end
    endtask

    task automatic check_int(input int got, input int want, input string tag);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Timeline of one run starting from the cycle the FSM sits in preparation.
    task automatic build_trace(input int lim, input int pause_extra);
        trace.delete();
        trace.push_back(mk(1, 0, last_end, 1, 0));
        for (int p = 0; p <= lim; p++) begin
            trace.push_back(mk(2, 0, p, 1, 0));
            for (int c = 0; c < T_ON + ((p == 0) ? pause_extra : 0); c++)
                trace.push_back(mk(3, rom[p], p, 1, 0));
            for (int c = 0; c < T_OFF; c++)
                trace.push_back(mk(4, 0, p, 1, 0));
            if (p != lim) trace.push_back(mk(5, 0, p, 1, 0));
        end
        trace.push_back(mk(10, 0, lim, 0, 1));
        trace.push_back(mk(0, 0, lim, 0, 0));
    endtask

    task automatic run_seq(input int lim, input bit hold, input int pause_extra,
                           input int change_at, input int abort_at, input string tag,
                           output int latency, output int led_cycles);
        limite = ADDR_W'(lim);
        build_trace(lim, pause_extra);
        iniciar = 1'b1;
        latency = -1;
        led_cycles = 0;
        for (int j = 0; j < trace.size(); j++) begin
            @(posedge clock); #1;
            if (!hold) iniciar = 1'b0;
            check_cycle(trace[j], tag, j);
            if (leds != 0) led_cycles++;
            if (pronto) latency = j + 1;
            if (j == change_at) limite = ADDR_W'(lim) ^ 4'hF;
            if (pause_extra > 0 && j == 2) pausa = 1'b1;
            if (pause_extra > 0 && j == 2 + pause_extra) pausa = 1'b0;
            if (j == abort_at) break;
        end
        if (abort_at < 0) last_end = lim;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clock); #1;
        check_cycle(mk(0, 0, 0, 0, 0), tag, 0);
        reset = 1'b0;
        last_end = 0;
    endtask

    vec_t vecs[5];
    int   lat, ledc;

    initial begin
        vecs[0] = '{lim: 0,  exp_latency: 9,   exp_led_cycles: 4};
        vecs[1] = '{lim: 1,  exp_latency: 17,  exp_led_cycles: 8};
        vecs[2] = '{lim: 3,  exp_latency: 33,  exp_led_cycles: 16};
        vecs[3] = '{lim: 7,  exp_latency: 65,  exp_led_cycles: 32};
        vecs[4] = '{lim: 15, exp_latency: 129, exp_led_cycles: 64};
        for (int i = 0; i < 16; i++) rom[i] = DATA_W'(1 << (i % 4));

        // Clock/reset
        repeat (2) @(posedge clock);
        #1;
        check_cycle(mk(0, 0, 0, 0, 0), "reset_state", 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_cycle(mk(0, 0, 0, 0, 0), "idle", 0);

        // Table-driven runs: full timeline plus pronto latency and lit-cycle count.
        foreach (vecs[v]) begin
            run_seq(vecs[v].lim, 1'b0, 0, -1, -1, "table_run", lat, ledc);
            check_int(lat, vecs[v].exp_latency, "table_latency");
            check_int(ledc, vecs[v].exp_led_cycles, "table_led_cycles");
            @(posedge clock); #1;
            check_cycle(mk(0, 0, last_end, 0, 0), "table_hold_end", v);
        end

        // Reset during the second value, then replay from address 0.
        run_seq(3, 1'b0, 0, -1, 11, "pre_reset", lat, ledc);
        do_reset("mid_reset");
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_cycle(mk(0, 0, 0, 0, 0), "post_reset_idle", i);
        end
        run_seq(3, 1'b0, 0, -1, -1, "replay", lat, ledc);
        check_int(lat, 33, "replay_latency");

        // iniciar held high throughout, limite changed mid-run.
        run_seq(2, 1'b1, 0, 3, -1, "held_run", lat, ledc);
        check_int(lat, 25, "held_latency");
        @(posedge clock); #1;
        check_cycle(mk(1, 0, 2, 1, 0), "held_restart", 0);
        iniciar = 1'b0;
        do_reset("held_cleanup");

`ifdef EXIBICAO_PAUSA_EN
        run_seq(1, 1'b0, 10, -1, -1, "pause_run", lat, ledc);
        check_int(lat, 27, "pause_latency");
        check_int(ledc, 18, "pause_led_cycles");
`endif

        // Randomized contents, limits and idle gaps.
        for (int r = 0; r < 8; r++) begin
            int gap;
            for (int i = 0; i < 16; i++) rom[i] = DATA_W'($urandom_range(0, 15));
            run_seq($urandom_range(0, 15), 1'b0, 0, -1, -1, "rand_run", lat, ledc);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(posedge clock); #1;
                check_cycle(mk(0, 0, last_end, 0, 0), "rand_gap", g);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exp5_unidade_exibicao.md
Name: exp5_unidade_exibicao

Overview:
Sequence presenter for the memory game: the transmit side of the jogada/memória interface, whose consumer is the existing compare control unit.
- On iniciar, reads the stored sequence from the synchronous ROM, address 0 up to limite.
- Drives each value onto the LEDs for T_ON cycles, then blanks them for T_OFF cycles.
- Pulses pronto when finished.
- Sits between the sequence ROM and the LED/display path; the top-level hands off to the compare control unit after pronto.

Parameters:
DATA_W, 4, width of one stored jogada (one-hot LED pattern)
ADDR_W, 4, ROM address width; sequence holds up to 2^ADDR_W positions
T_ON, 1000, cycles each value is shown; legal range 1..65535
T_OFF, 500, cycles LEDs stay blank after each value; legal range 1..65535

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clock
iniciar  in  1  start request, level-sampled in state inicial only
limite  in  ADDR_W  last address to present (inclusive); sampled on leaving preparacao
dado  in  DATA_W  ROM read data, valid one cycle after endereco changes
endereco  out  ADDR_W  ROM address
leds  out  DATA_W  value presented to the player
exibindo  out  1  high in every state except inicial and fim
pronto  out  1  one-cycle pulse in state fim
db_estado  out  4  current state code, debug

Behaviour:
- Moore FSM, registered state; all outputs decode the current state or registers.
- On reset: state inicial, endereco=0, leds=0, exibindo=0, pronto=0, timer=0, limite register=0.
- States and codes:
  - inicial (0): iniciar=1 -> preparacao, else stay.
  - preparacao (1): endereco<=0, timer<=0, limite latched -> carrega.
  - carrega (2): one-cycle wait for ROM latency -> mostra.
  - mostra (3): leds=dado; timer counts 0..T_ON-1. At T_ON-1: timer<=0 -> apaga. Lasts exactly T_ON cycles.
  - apaga (4): leds=0; timer counts 0..T_OFF-1. At T_OFF-1: timer<=0; if endereco==limite -> fim, else -> proximo. Lasts exactly T_OFF cycles.
  - proximo (5): endereco<=endereco+1 -> carrega.
  - fim (A): pronto=1 for exactly one cycle -> inicial.
  - Any unused code -> inicial; db_estado=F.
- Timing: iniciar sampled high at edge k gives preparacao at k+1, carrega at k+2, first value on leds from k+3.
- Cost per position is T_ON+T_OFF+2 cycles; for the last position it is T_ON+T_OFF+1 cycles, then one fim cycle.
- leds is driven only in mostra; it is 0 in all other states.
- endereco holds its value after fim until the next preparacao.
- limite is latched at preparacao; later changes have no effect on the current run.
- limite=0: exactly one value is shown.
- limite=2^ADDR_W-1: all positions are shown; endereco never wraps, because fim is taken before increment.
- iniciar while exibindo=1 is ignored.
- reset asserted mid-sequence: the next cycle is inicial with all outputs at reset values; no pronto pulse.
- Timer is 16 bits wide; it saturation-free counts only in mostra/apaga and holds 0 elsewhere.

Optional Feature:
Macro EXIBICAO_PAUSA_EN.
- Defined: adds input pausa (1 bit).
  - While pausa=1 in mostra or apaga, the timer and state freeze; leds keep their current value.
  - pausa has no effect in other states.
  - Releasing pausa resumes counting from the frozen value.
- Not defined: port is absent and the timer always advances.

Test Plan:
- T_ON=4, T_OFF=2, ROM[0..3]=1,2,4,8, limite=3, iniciar pulse -> leds shows 1,2,4,8, each for 4 cycles, separated by 2 zero cycles. pronto pulses once, 33 cycles after the iniciar edge. db_estado sequence: 0,1,2,3,4,5,2,...,A,0.
- limite=0, ROM[0]=4 -> leds=4 for exactly T_ON cycles, endereco stays 0, pronto at cycle 3+T_ON+T_OFF.
- ADDR_W=2, limite=3 -> endereco reaches 3 and never wraps to 0 before fim; 4 values shown.
- reset raised during the second mostra -> next cycle: state 0, leds=0, endereco=0, exibindo=0, no pronto. A subsequent iniciar replays from address 0.
- iniciar held high for the whole run -> a single run completes; after fim, inicial immediately restarts (preparacao on the following cycle). limite changed mid-run has no effect.
- EXIBICAO_PAUSA_EN defined: pausa=1 for 10 cycles during mostra -> that value is shown T_ON+10 cycles; the total run is extended by exactly 10 cycles.
